// File: rtl/pipelined_alu_pkg.sv
// Shared definitions for pipelined_alu: opcodes, flag bit positions, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipelined_alu_pkg;

    // Operation codes; 4'b1010..4'b1111 are illegal.
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_DIV   = 4'b0010;
    localparam logic [3:0] ALU_MUL   = 4'b0011;
    localparam logic [3:0] ALU_PASS2 = 4'b0100;
    localparam logic [3:0] ALU_PASS1 = 4'b0101;
    localparam logic [3:0] ALU_AND   = 4'b0110;
    localparam logic [3:0] ALU_OR    = 4'b0111;
    localparam logic [3:0] ALU_ADDU  = 4'b1000;
    localparam logic [3:0] ALU_SLT   = 4'b1001;

    // Flag vector layout: {illegal, div0, ovf, zero, sign}
    localparam int FLAGS_W     = 5;
    localparam int FLG_SIGN    = 0;
    localparam int FLG_ZERO    = 1;
    localparam int FLG_OVF     = 2;
    localparam int FLG_DIV0    = 3;
    localparam int FLG_ILLEGAL = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic [FLAGS_W-1:0] pack_flags(
        input logic illegal,
        input logic div0,
        input logic ovf,
        input logic zero,
        input logic sign
    );
        logic [FLAGS_W-1:0] f;
        f              = '0;
        f[FLG_ILLEGAL] = illegal;
        f[FLG_DIV0]    = div0;
        f[FLG_OVF]     = ovf;
        f[FLG_ZERO]    = zero;
        f[FLG_SIGN]    = sign;
        return f;
    endfunction

endpackage

// File: rtl/alu_divider.sv
// Unsigned restoring divider on operand magnitudes, one quotient bit per cycle.
// Latency: WIDTH cycles after i_start; o_done marks the last iteration cycle.
// Backpressure: none; caller must not restart while busy and must take results on o_done.
//
// Ports: clk, rst_n (async active-low); i_start loads i_dividend/i_divisor;
//        o_done/o_quot/o_rem present the outcome of the final iteration combinationally
//        so the caller can register it on the same edge the divider finishes.
module alu_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;   // shifts dividend bits out, quotient bits in
    logic [WIDTH-1:0] r_div;

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quot_nxt;

    // Partial remainder needs one extra bit before the trial subtract.
    assign w_shift    = {r_rem, r_quot[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_div});
    assign w_rem_nxt  = w_ge ? WIDTH'(w_shift - {1'b0, r_div}) : w_shift[WIDTH-1:0];
    assign w_quot_nxt = {r_quot[WIDTH-2:0], w_ge};

    assign o_done = r_busy & (r_cnt == CNT_W'(WIDTH - 1));
    assign o_quot = w_quot_nxt;
    assign o_rem  = w_rem_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quot <= '0;
            r_div  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quot <= i_dividend;
            r_div  <= i_divisor;
        end else if (r_busy) begin
            r_rem  <= w_rem_nxt;
            r_quot <= w_quot_nxt;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipelined_alu.sv
// Handshaked registered ALU with status flags; signed divide runs iteratively in alu_divider.
// Latency: 1 cycle accept->out_valid for all ops except DIV (WIDTH+1 cycles; DIV by zero is 1).
// Backpressure: one op in flight; in_ready drops while busy or holding an unconsumed result.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready with op1, op2 (signed WIDTH), op (4b);
//        out_valid/out_ready with result (2*WIDTH) and flags {illegal, div0, ovf, zero, sign}.
module pipelined_alu
    import pipelined_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    input  logic [3:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [FLAGS_W-1:0] flags
);

    localparam int RES_W = 2 * WIDTH;

    alu_state_e r_state, w_state_nxt;

    logic [RES_W-1:0]   r_result;
    logic [FLAGS_W-1:0] r_flags;
    logic               r_q_neg;     // quotient negative: operand signs differ
    logic               r_r_neg;     // remainder takes dividend sign
    logic               r_div_ovf;   // most-negative / -1

    logic               w_accept;
    logic               w_div_start;
    logic               w_div_done;
    logic [WIDTH-1:0]   w_mag1, w_mag2;
    logic [WIDTH-1:0]   w_dv_quot, w_dv_rem;
    logic [WIDTH-1:0]   w_q_fix, w_r_fix;
    logic [RES_W-1:0]   w_div_res;
    logic               w_div_minovf;

    logic [RES_W-1:0]   w_a_ext, w_b_ext;
    logic [RES_W-1:0]   w_add, w_sub, w_mul, w_addu;
    logic [RES_W-1:0]   w_res;
    logic               w_ovf, w_ill, w_div0;

    assign w_accept    = in_valid & in_ready;
    assign w_div_start = w_accept & (op == ALU_DIV) & (op2 != '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = w_div_start ? ST_DIV : ST_DONE;
            end
            ST_DIV: begin
                if (w_div_done) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // Consume and accept in the same cycle keeps the pipe full.
                if (w_accept)       w_state_nxt = w_div_start ? ST_DIV : ST_DONE;
                else if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // ---------------- single-cycle datapath ----------------
    assign w_a_ext = {{WIDTH{op1[WIDTH-1]}}, op1};
    assign w_b_ext = {{WIDTH{op2[WIDTH-1]}}, op2};
    assign w_add   = w_a_ext + w_b_ext;
    assign w_sub   = w_a_ext - w_b_ext;
    assign w_mul   = $signed(w_a_ext) * $signed(w_b_ext);
    assign w_addu  = {{WIDTH{1'b0}}, op1} + {{WIDTH{1'b0}}, op2};

    always_comb begin
        w_res  = '0;
        w_ovf  = 1'b0;
        w_ill  = 1'b0;
        w_div0 = 1'b0;
        case (op)
            ALU_ADD: begin
                w_res = w_add;
                w_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) & (w_add[WIDTH-1] != op1[WIDTH-1]);
            end
            ALU_SUB: begin
                w_res = w_sub;
                w_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) & (w_sub[WIDTH-1] != op1[WIDTH-1]);
            end
            ALU_DIV: begin
                // Only reaches the result register when dividing by zero.
                w_res  = {op1, {WIDTH{1'b1}}};
                w_div0 = 1'b1;
            end
            ALU_MUL:   w_res = w_mul;
            ALU_PASS2: w_res = w_b_ext;
            ALU_PASS1: w_res = w_a_ext;
            ALU_AND:   w_res = w_a_ext & w_b_ext;
            ALU_OR:    w_res = w_a_ext | w_b_ext;
            ALU_ADDU:  w_res = w_addu;
            ALU_SLT:   w_res = {{(RES_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
            default:   w_ill = 1'b1;
        endcase
    end

    // ---------------- divide: magnitudes in, signs applied on the way out ----------------
    assign w_mag1       = op1[WIDTH-1] ? -op1 : op1;
    assign w_mag2       = op2[WIDTH-1] ? -op2 : op2;
    assign w_div_minovf = (op1 == {1'b1, {(WIDTH-1){1'b0}}}) & (op2 == {WIDTH{1'b1}});

    alu_divider #(.WIDTH(WIDTH)) u_divider (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_div_start),
        .i_dividend (w_mag1),
        .i_divisor  (w_mag2),
        .o_done     (w_div_done),
        .o_quot     (w_dv_quot),
        .o_rem      (w_dv_rem)
    );

    // Magnitude quotient of most-negative/-1 is 2^(WIDTH-1), which already reads as
    // the wrapped most-negative value, so no special case is needed here.
    assign w_q_fix   = r_q_neg ? -w_dv_quot : w_dv_quot;
    assign w_r_fix   = r_r_neg ? -w_dv_rem  : w_dv_rem;
    assign w_div_res = {w_r_fix, w_q_fix};

    // ---------------- result / flag registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result  <= '0;
            r_flags   <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_div_ovf <= 1'b0;
        end else begin
            if (w_div_start) begin
                r_q_neg   <= op1[WIDTH-1] ^ op2[WIDTH-1];
                r_r_neg   <= op1[WIDTH-1];
                r_div_ovf <= w_div_minovf;
            end else if (w_accept) begin
                r_result <= w_res;
                r_flags  <= pack_flags(w_ill, w_div0, w_ovf, (w_res == '0), w_res[RES_W-1]);
            end else if (w_div_done && (r_state == ST_DIV)) begin
                r_result <= w_div_res;
                r_flags  <= pack_flags(1'b0, 1'b0, r_div_ovf, (w_div_res == '0),
                                       w_div_res[RES_W-1]);
            end
        end
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule

// File: tb/tb_pipelined_alu.sv
module tb_pipelined_alu;

    localparam int W = 16;

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_DIV = 4'h2, OP_MUL = 4'h3;
    localparam logic [3:0] OP_PASS2 = 4'h4, OP_PASS1 = 4'h5, OP_AND = 4'h6, OP_OR = 4'h7;
    localparam logic [3:0] OP_ADDU = 4'h8, OP_SLT = 4'h9, OP_BAD = 4'hB;

    // {illegal, div0, ovf, zero, sign}
    localparam logic [4:0] F_NONE = 5'b00000, F_SIGN = 5'b00001, F_ZERO = 5'b00010;
    localparam logic [4:0] F_OVF  = 5'b00100, F_DIV0 = 5'b01000, F_ILL  = 5'b10000;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  op1       = '0;
    logic [W-1:0]  op2       = '0;
    logic [3:0]    op        = '0;
    logic          in_ready;
    logic          out_valid;
    logic [2*W-1:0] result;
    logic [4:0]    flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    pipelined_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every presented result is compared against the scoreboard head,
    // including cycles where it is held under backpressure; popped on consume.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result 0x%08h with no expected entry", result);
            end else begin
                mon_e = sb_q[0];
                chk({mon_e.name, "_result"}, result, mon_e.res);
                chk({mon_e.name, "_flags"}, {27'd0, flags}, {27'd0, mon_e.flg});
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [31:0] er, input logic [4:0] ef, input string name,
                         output int waited);
        exp_t e;
        waited   = 0;
        op       = o;
        op1      = a;
        op2      = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 60) begin
                checks++;
                errors++;
                $display("FAIL %s_accept: in_ready never rose within 60 cycles", name);
                break;
            end
        end
        e.res  = er;
        e.flg  = ef;
        e.name = name;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic lat1(input string name);
        @(negedge clk);
        chk({name, "_lat1"}, {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic div_lat(input string name);
        int  k;
        bit  seen;
        bit  busy_ready;
        k          = 0;
        seen       = 1'b0;
        busy_ready = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (out_valid) seen = 1'b1;
            else if (in_ready) busy_ready = 1'b1;
        end
        chk({name, "_latency"}, (seen ? k : 0), 32'd17);
        chk({name, "_in_ready_low"}, {31'd0, busy_ready}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result",    result,             32'd0);
        chk("rst_flags",     {27'd0, flags},     32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(OP_ADD, 16'h7FFF, 16'h0001, 32'h0000_8000, F_OVF, "add_ovf", w);
        lat1("add_ovf");

        // back-to-back stream, out_ready held high
        issue(OP_ADD, 16'hFFFF, 16'h0001, 32'h0000_0000, F_ZERO, "add_zero", w);
        issue(OP_SUB, 16'h0005, 16'h0007, 32'hFFFF_FFFE, F_SIGN, "sub_neg", w);
        issue(OP_SUB, 16'h8000, 16'h0001, 32'hFFFF_7FFF, F_OVF | F_SIGN, "sub_ovf", w);

        issue(OP_DIV, 16'hFFF9, 16'h0002, 32'hFFFF_FFFD, F_SIGN, "div_m7_2", w);
        div_lat("div_m7_2");

        issue(OP_DIV, 16'h0005, 16'h0000, 32'h0005_FFFF, F_DIV0, "div_by0", w);
        lat1("div_by0");

        issue(OP_DIV, 16'h8000, 16'hFFFF, 32'h0000_8000, F_OVF, "div_min", w);
        div_lat("div_min");

        // hold MUL result for 5 cycles with a competing request waiting
        out_ready = 1'b0;
        issue(OP_MUL, 16'hFFFD, 16'h0004, 32'hFFFF_FFF4, F_SIGN, "mul_hold", w);
        fork
            issue(OP_PASS1, 16'h1234, 16'h0000, 32'h0000_1234, F_NONE, "pass1_b2b", w);
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        chk("hold_wait_cycles", w, 32'd5);
        @(negedge clk);
        chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        issue(OP_BAD,   16'h0005, 16'h0003, 32'h0000_0000, F_ILL | F_ZERO, "illegal", w);
        issue(OP_SLT,   16'hFFFF, 16'h0001, 32'h0000_0001, F_NONE, "slt_true", w);
        issue(OP_SLT,   16'h0001, 16'hFFFF, 32'h0000_0000, F_ZERO, "slt_false", w);
        issue(OP_AND,   16'hF0F0, 16'h0FF0, 32'h0000_00F0, F_NONE, "and", w);
        issue(OP_OR,    16'h8000, 16'h0001, 32'hFFFF_8001, F_SIGN, "or", w);
        issue(OP_PASS2, 16'h0000, 16'hFFFF, 32'hFFFF_FFFF, F_SIGN, "pass2", w);
        issue(OP_ADDU,  16'hFFFF, 16'h0001, 32'h0001_0000, F_NONE, "addu", w);
        drain();

        // reset in the middle of a divide: no result may ever appear for it
        issue(OP_DIV, 16'd100, 16'd7, 32'h0002_000E, F_NONE, "div_abort", w);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(OP_ADD, 16'h0002, 16'h0003, 32'h0000_0005, F_NONE, "add_after_rst", w);
        lat1("add_after_rst");
        repeat (25) @(posedge clk);
        #1;
        drain();

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
